// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Purpose  : Write-back pipeline stage. It captures the instruction leaving
//            MEM, selects load data or the ALU result, and drives the
//            register-file write port one cycle later. It also exposes the
//            pending write as a forwarding source and counts retired
//            instructions.
// Ports    : clk, rst                      - clock, synchronous active-high reset
//            mem_valid/mem_reg_write/mem_to_reg/mem_dest/mem_alu_result/
//            mem_read_data                 - instruction arriving from MEM
//            stall, flush                  - pipeline control
//            reg_write_en/dest/data        - register-file write port
//            fwd_valid/fwd_dest/fwd_data   - forwarding source
//            retire_count                  - 16-bit wrapping retirement count
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic              mem_reg_write,
    input  logic              mem_to_reg,
    input  logic [ADDR_W-1:0] mem_dest,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              stall,
    input  logic              flush,
    output logic              reg_write_en,
    output logic [ADDR_W-1:0] reg_write_dest,
    output logic [DATA_W-1:0] reg_write_data,
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_dest,
    output logic [DATA_W-1:0] fwd_data,
    output logic [15:0]       retire_count
);

    logic              wb_valid_q;
    logic              wb_reg_write_q;
    logic [ADDR_W-1:0] wb_dest_q;
    logic [DATA_W-1:0] wb_data_q;
    logic [15:0]       retire_count_q;

    logic [DATA_W-1:0] wb_data_d;
    logic              w_capture;
    logic              w_retire;
    logic              w_dest_nonzero;

    // Select the write-back value ahead of the register so only one
    // DATA_W word is stored.
    assign wb_data_d      = mem_to_reg ? mem_read_data : mem_alu_result;
    assign w_capture      = !flush && !stall;
    // The instruction in WB retires on the edge where it leaves the stage
    // normally; a flush discards it and a stall keeps it in place.
    assign w_retire       = wb_valid_q && !stall && !flush;
    assign w_dest_nonzero = (wb_dest_q != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q     <= 1'b0;
            wb_reg_write_q <= 1'b0;
            wb_dest_q      <= '0;
            wb_data_q      <= '0;
            retire_count_q <= 16'h0000;
        end else begin
            if (flush) begin
                // Remaining fields are don't-care once invalid; holding them
                // avoids needless toggling.
                wb_valid_q <= 1'b0;
            end else if (w_capture) begin
                wb_valid_q     <= mem_valid;
                wb_reg_write_q <= mem_reg_write;
                wb_dest_q      <= mem_dest;
                wb_data_q      <= wb_data_d;
            end
            if (w_retire) begin
                retire_count_q <= retire_count_q + 16'd1;
            end
        end
    end

    // The write port is gated by the live stall so a held instruction
    // commits exactly once, in the first unstalled cycle.
    assign reg_write_en   = wb_valid_q && wb_reg_write_q && w_dest_nonzero && !stall;
    assign reg_write_dest = wb_dest_q;
    assign reg_write_data = wb_data_q;

    // Forwarding reflects the pending write regardless of stall.
    assign fwd_valid      = wb_valid_q && wb_reg_write_q && w_dest_nonzero;
    assign fwd_dest       = wb_dest_q;
    assign fwd_data       = wb_data_q;

    assign retire_count   = retire_count_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage
// Purpose  : Directed self-checking bench for wb_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    logic              clk;
    logic              rst;
    logic              mem_valid;
    logic              mem_reg_write;
    logic              mem_to_reg;
    logic [ADDR_W-1:0] mem_dest;
    logic [DATA_W-1:0] mem_alu_result;
    logic [DATA_W-1:0] mem_read_data;
    logic              stall;
    logic              flush;
    logic              reg_write_en;
    logic [ADDR_W-1:0] reg_write_dest;
    logic [DATA_W-1:0] reg_write_data;
    logic              fwd_valid;
    logic [ADDR_W-1:0] fwd_dest;
    logic [DATA_W-1:0] fwd_data;
    logic [15:0]       retire_count;

    int errors;
    int checks;

    wb_stage #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_valid      (mem_valid),
        .mem_reg_write  (mem_reg_write),
        .mem_to_reg     (mem_to_reg),
        .mem_dest       (mem_dest),
        .mem_alu_result (mem_alu_result),
        .mem_read_data  (mem_read_data),
        .stall          (stall),
        .flush          (flush),
        .reg_write_en   (reg_write_en),
        .reg_write_dest (reg_write_dest),
        .reg_write_data (reg_write_data),
        .fwd_valid      (fwd_valid),
        .fwd_dest       (fwd_dest),
        .fwd_data       (fwd_data),
        .retire_count   (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r,
                         input logic [ADDR_W-1:0] d, input logic [DATA_W-1:0] alu,
                         input logic [DATA_W-1:0] rd);
        mem_valid      = v;
        mem_reg_write  = rw;
        mem_to_reg     = m2r;
        mem_dest       = d;
        mem_alu_result = alu;
        mem_read_data  = rd;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        stall  = 1'b0;
        flush  = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000);
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state
        chk("rst_en",    {31'd0, reg_write_en}, 32'd0);
        chk("rst_fwd",   {31'd0, fwd_valid},    32'd0);
        chk("rst_dest",  {29'd0, reg_write_dest}, 32'd0);
        chk("rst_data",  {16'd0, reg_write_data}, 32'd0);
        chk("rst_count", {16'd0, retire_count}, 32'd0);

        // ALU write to R3
        drive(1'b1, 1'b1, 1'b0, 3'd3, 16'h1234, 16'h5555);
        tick();
        mem_valid = 1'b0;
        #1;
        chk("alu_en",    {31'd0, reg_write_en}, 32'd1);
        chk("alu_dest",  {29'd0, reg_write_dest}, 32'd3);
        chk("alu_data",  {16'd0, reg_write_data}, 32'h1234);
        chk("alu_fwd",   {31'd0, fwd_valid},    32'd1);
        chk("alu_fdest", {29'd0, fwd_dest},     32'd3);
        chk("alu_fdata", {16'd0, fwd_data},     32'h1234);
        chk("alu_cnt0",  {16'd0, retire_count}, 32'd0);
        tick();
        chk("alu_cnt1",  {16'd0, retire_count}, 32'd1);
        chk("alu_en_off",{31'd0, reg_write_en}, 32'd0);

        // Load write to R5 selects read data
        drive(1'b1, 1'b1, 1'b1, 3'd5, 16'h0001, 16'hBEEF);
        tick();
        mem_valid = 1'b0;
        #1;
        chk("ld_en",   {31'd0, reg_write_en}, 32'd1);
        chk("ld_dest", {29'd0, reg_write_dest}, 32'd5);
        chk("ld_data", {16'd0, reg_write_data}, 32'hBEEF);
        tick();
        chk("ld_cnt",  {16'd0, retire_count}, 32'd2);

        // Write to R0 suppressed but still retires
        drive(1'b1, 1'b1, 1'b0, 3'd0, 16'hFFFF, 16'h0000);
        tick();
        mem_valid = 1'b0;
        #1;
        chk("r0_en",  {31'd0, reg_write_en}, 32'd0);
        chk("r0_fwd", {31'd0, fwd_valid},    32'd0);
        tick();
        chk("r0_cnt", {16'd0, retire_count}, 32'd3);

        // Stall for three cycles, then one write and one retirement
        drive(1'b1, 1'b1, 1'b0, 3'd2, 16'h00AA, 16'h0000);
        tick();
        mem_valid = 1'b0;
        stall     = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stl_en",   {31'd0, reg_write_en}, 32'd0);
            chk("stl_fwd",  {31'd0, fwd_valid},    32'd1);
            chk("stl_dest", {29'd0, reg_write_dest}, 32'd2);
            chk("stl_data", {16'd0, reg_write_data}, 32'h00AA);
            chk("stl_cnt",  {16'd0, retire_count}, 32'd3);
            tick();
        end
        stall = 1'b0;
        #1;
        chk("stl_rel_en", {31'd0, reg_write_en}, 32'd1);
        tick();
        chk("stl_rel_cnt", {16'd0, retire_count}, 32'd4);
        chk("stl_rel_off", {31'd0, reg_write_en}, 32'd0);

        // Flush coincident with stall discards the held instruction
        drive(1'b1, 1'b1, 1'b0, 3'd4, 16'h0044, 16'h0000);
        tick();
        mem_valid = 1'b0;
        stall     = 1'b1;
        flush     = 1'b1;
        #1;
        chk("fl_pre_fwd", {31'd0, fwd_valid}, 32'd1);
        tick();
        stall = 1'b0;
        flush = 1'b0;
        #1;
        chk("fl_fwd", {31'd0, fwd_valid},    32'd0);
        chk("fl_en",  {31'd0, reg_write_en}, 32'd0);
        chk("fl_cnt", {16'd0, retire_count}, 32'd4);
        tick();
        chk("fl_cnt2", {16'd0, retire_count}, 32'd4);

        // Drive retire_count up to 16'hFFFF: 65531 edges with a valid
        // instruction every cycle retire 65530 (the first edge only captures).
        drive(1'b1, 1'b0, 1'b0, 3'd1, 16'h0000, 16'h0000);
        for (int n = 0; n < 65531; n++) begin
            tick();
        end
        mem_valid = 1'b0;
        chk("wr_fffe", {16'd0, retire_count}, 32'hFFFE);
        tick();
        chk("wr_ffff", {16'd0, retire_count}, 32'hFFFF);
        drive(1'b1, 1'b1, 1'b0, 3'd6, 16'h0066, 16'h0000);
        tick();
        mem_valid = 1'b0;
        #1;
        chk("wr_hold", {16'd0, retire_count}, 32'hFFFF);
        tick();
        chk("wr_zero", {16'd0, retire_count}, 32'h0000);

        // Reset mid-stall
        drive(1'b1, 1'b1, 1'b0, 3'd7, 16'h7777, 16'h0000);
        tick();
        mem_valid = 1'b0;
        stall     = 1'b1;
        tick();
        chk("rs_fwd_pre", {31'd0, fwd_valid}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rs_en",    {31'd0, reg_write_en}, 32'd0);
        chk("rs_fwd",   {31'd0, fwd_valid},    32'd0);
        chk("rs_dest",  {29'd0, reg_write_dest}, 32'd0);
        chk("rs_data",  {16'd0, reg_write_data}, 32'd0);
        chk("rs_count", {16'd0, retire_count}, 32'd0);
        stall = 1'b0;
        #1;
        chk("rs_en_unstall", {31'd0, reg_write_en}, 32'd0);
        tick();
        chk("rs_count2", {16'd0, retire_count}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
